kws_seq_ctrl: RTL and testbench

Wishbone-controlled inference sequencer for the keyword-spotting accelerator. It sits between the management-SoC Wishbone slave port and the KWS layer engine. It exposes a small register bank and steps the engine through a programmable number of layers, one start/done handshake per layer. It also provides per-layer timeout, error capture, cycle counting and an interrupt.

---
 rtl/kws_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_kws_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kws_seq_ctrl.sv
// Wishbone-controlled inference sequencer for the KWS layer engine: register bank,
// per-layer start/done stepping, per-layer timeout, sticky status, cycle counter, IRQ.
module kws_seq_ctrl #(
  parameter int          NUM_LAYERS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  localparam int         LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          layer_start_o,
  output logic [LW-1:0] layer_idx_o,
  input  logic          layer_done_i,
  input  logic          layer_err_i,
  output logic          busy_o,
  output logic          irq_o,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  localparam logic [7:0] MAX_CNT  = 8'(NUM_LAYERS);
  localparam logic [5:0] OFF_CTRL = 6'd0;
  localparam logic [5:0] OFF_STAT = 6'd1;
  localparam logic [5:0] OFF_LCNT = 6'd2;
  localparam logic [5:0] OFF_TMO  = 6'd3;
  localparam logic [5:0] OFF_CYC  = 6'd4;

  state_t        state;
  logic [LW-1:0] idx;
  logic [15:0]   tmr;
  logic [31:0]   cycles;
  logic          done_f, err_f, tmo_f, irq_en;
  logic [7:0]    layer_cnt;
  logic [15:0]   timeout_r;
  logic [31:0]   rdata;

  logic       page_hit, req, wr_en, busy;
  logic [5:0] off;
  logic       ctrl_wr, stat_wr, lcnt_wr, tmo_wr;
  logic       start_req, abort_req;
  logic       in_wait, ev_err, ev_done, ev_tmo, ev_fin, last_layer;
  logic       unused_bits;

  // Wishbone classic: ack rises the cycle after cyc&stb and lasts one cycle; a new
  // ack needs ack low first. Writes commit on the edge that ends the ack cycle and
  // read data is driven only while ack is high.
  assign page_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req      = wbs_cyc_i & wbs_stb_i & page_hit;
  assign wr_en    = req & wbs_we_i & wbs_ack_o;
  assign off      = wbs_adr_i[7:2];
  assign busy     = (state != S_IDLE);

  assign ctrl_wr   = wr_en & (off == OFF_CTRL) & wbs_sel_i[0];
  assign stat_wr   = wr_en & (off == OFF_STAT) & wbs_sel_i[0];
  assign lcnt_wr   = wr_en & (off == OFF_LCNT) & wbs_sel_i[0] & ~busy;
  assign tmo_wr    = wr_en & (off == OFF_TMO) & ~busy;
  assign start_req = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
  assign abort_req = ctrl_wr & wbs_dat_i[1] & busy;

  // Engine events only count in WAIT; abort masks them, err beats done beats timeout.
  assign in_wait    = (state == S_WAIT) & ~abort_req;
  assign ev_err     = in_wait & layer_err_i;
  assign ev_done    = in_wait & layer_done_i & ~layer_err_i;
  assign ev_tmo     = in_wait & ~layer_done_i & ~layer_err_i & (timeout_r != 16'd0) & (tmr == 16'd1);
  assign ev_fin     = (state == S_FINISH) & ~abort_req;
  assign last_layer = (8'(idx) == layer_cnt - 8'd1);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_CTRL: rdata = {29'd0, irq_en, 2'b00};
      OFF_STAT: rdata = {16'd0, 8'(idx), 4'd0, tmo_f, err_f, done_f, busy};
      OFF_LCNT: rdata = {24'd0, layer_cnt};
      OFF_TMO:  rdata = {16'd0, timeout_r};
      OFF_CYC:  rdata = cycles;
      default:  rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req & ~wbs_ack_o;
      wbs_dat_o <= (req & ~wbs_ack_o & ~wbs_we_i) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      idx       <= '0;
      tmr       <= 16'd0;
      cycles    <= 32'd0;
      done_f    <= 1'b0;
      err_f     <= 1'b0;
      tmo_f     <= 1'b0;
      irq_en    <= 1'b0;
      layer_cnt <= MAX_CNT;
      timeout_r <= 16'd0;
    end else begin
      if (busy) cycles <= cycles + 32'd1;
      if (abort_req) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start_req) begin
            state  <= S_ISSUE;
            idx    <= '0;
            cycles <= 32'd0;
          end
          S_ISSUE: begin
            tmr   <= timeout_r;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (ev_err) begin
              state <= S_FINISH;
            end else if (ev_done) begin
              if (last_layer) begin
                state <= S_FINISH;
              end else begin
                idx   <= idx + LW'(1);
                state <= S_ISSUE;
              end
            end else if (ev_tmo) begin
              state <= S_FINISH;
            end else if (tmr != 16'd0) begin
              tmr <= tmr - 16'd1;
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
      // Hardware set beats a same-cycle write-1-to-clear.
      done_f <= ev_fin | (done_f & ~(stat_wr & wbs_dat_i[1]));
      err_f  <= ev_err | (err_f & ~(stat_wr & wbs_dat_i[2]));
      tmo_f  <= ev_tmo | (tmo_f & ~(stat_wr & wbs_dat_i[3]));
      if (ctrl_wr) irq_en <= wbs_dat_i[2];
      if (lcnt_wr) begin
        if (wbs_dat_i[7:0] == 8'd0)        layer_cnt <= 8'd1;
        else if (wbs_dat_i[7:0] > MAX_CNT) layer_cnt <= MAX_CNT;
        else                               layer_cnt <= wbs_dat_i[7:0];
      end
      if (tmo_wr && wbs_sel_i[0]) timeout_r[7:0]  <= wbs_dat_i[7:0];
      if (tmo_wr && wbs_sel_i[1]) timeout_r[15:8] <= wbs_dat_i[15:8];
    end
  end

  assign layer_start_o = (state == S_ISSUE);
  assign layer_idx_o   = idx;
  assign busy_o        = busy;
  assign irq_o         = irq_en & (done_f | err_f | tmo_f);
  assign dbg_state     = state;

endmodule

// File: tb/tb_kws_seq_ctrl.sv
// Bench for kws_seq_ctrl: register vectors from a table, then hand-written run
// sequences driven against a small engine model that answers start pulses.
module tb_kws_seq_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] rdat;
  logic        layer_start;
  logic [1:0]  layer_idx;
  logic        layer_done, layer_err;
  logic        busy, irq;
  logic [1:0]  dbg_state;

  kws_seq_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .layer_start_o(layer_start), .layer_idx_o(layer_idx),
    .layer_done_i(layer_done), .layer_err_i(layer_err),
    .busy_o(busy), .irq_o(irq), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [1:0]  start_log[$];

  // Engine model: mode 0 never answers, 1 pulses done eng_delay cycles after each
  // start, 2 does the same but also raises err together with done on layer 1.
  int eng_mode  = 0;
  int eng_delay = 5;
  int cd        = 0;

  initial begin
    layer_done = 1'b0;
    layer_err  = 1'b0;
    forever begin
      @(negedge clk);
      layer_done = 1'b0;
      layer_err  = 1'b0;
      if (layer_start) begin
        start_log.push_back(layer_idx);
        cd = (eng_mode != 0) ? eng_delay : 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          layer_done = 1'b1;
          if (eng_mode == 2 && layer_idx == 2'd1) layer_err = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] s, input logic w);
    int n;
    logic [31:0] e;
    string nm;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = BASE + {24'd0, off}; dat = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      chk("ack_missing", {31'd0, ack}, 32'd1);
      if (!w) begin
        void'(exp_q.pop_front());
        void'(name_q.pop_front());
      end
    end else begin
      chk("ack_latency", n, 32'd1);
      if (!w) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, rdat, e);
      end
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_width", {31'd0, ack}, 32'd0);
    chk("dat_idle", rdat, 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd);
    xfer(off, wd, 4'hF, 1'b1);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    xfer(off, 32'd0, 4'hF, 1'b0);
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while (busy && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_starts(input int cnt, input int max);
    int n = 0;
    while (start_log.size() < cnt && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("start_wait", start_log.size(), cnt);
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < start_log.size()) ? {30'd0, start_log[i]} : 32'hFF;
  endfunction

  typedef struct {
    logic [7:0]  off;
    logic        w;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ack_cnt;
    vecs[0]  = '{8'h08, 1'b1, 4'hF, 32'd0,         32'd1,      "lc_zero_clamp"};
    vecs[1]  = '{8'h08, 1'b1, 4'hF, 32'd9,         32'd4,      "lc_high_clamp"};
    vecs[2]  = '{8'h08, 1'b1, 4'hF, 32'd3,         32'd3,      "lc_plain"};
    vecs[3]  = '{8'h08, 1'b1, 4'hE, 32'd2,         32'd3,      "lc_sel_gated"};
    vecs[4]  = '{8'h0C, 1'b1, 4'h1, 32'h0000_1234, 32'h34,     "to_byte0"};
    vecs[5]  = '{8'h0C, 1'b1, 4'h2, 32'h0000_AB00, 32'hAB34,   "to_byte1"};
    vecs[6]  = '{8'h0C, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'hFFFF,   "to_full"};
    vecs[7]  = '{8'h0C, 1'b1, 4'hF, 32'd0,         32'd0,      "to_zero"};
    vecs[8]  = '{8'h20, 1'b1, 4'hF, 32'hDEAD,      32'd0,      "unmapped"};
    vecs[9]  = '{8'h00, 1'b1, 4'hF, 32'd4,         32'd4,      "ctrl_irq_en"};
    vecs[10] = '{8'h00, 1'b1, 4'hF, 32'd0,         32'd0,      "ctrl_clear"};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; dat = 32'd0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_start", {31'd0, layer_start}, 32'd0);
    chk("rst_idx", {30'd0, layer_idx}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rd(8'h00, 32'd0, "rst_ctrl");
    rd(8'h04, 32'd0, "rst_status");
    rd(8'h08, 32'd4, "rst_layer_cnt");
    rd(8'h0C, 32'd0, "rst_timeout");
    rd(8'h10, 32'd0, "rst_cycles");

    // Out-of-page access gets no ack.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'h100;
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (ack) ack_cnt++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("oop_no_ack", ack_cnt, 32'd0);
    tick(1);

    // Register vectors.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].w) xfer(vecs[i].off, vecs[i].wd, vecs[i].s, 1'b1);
      rd(vecs[i].off, vecs[i].exp, vecs[i].nm);
    end

    // START and ABORT together: no run.
    start_log.delete();
    wr(8'h00, 32'd3);
    tick(3);
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    chk("start_abort_pulses", start_log.size(), 32'd0);

    // Three-layer run, done 5 cycles after each start; each layer is ISSUE plus
    // 5 WAIT cycles, and FINISH adds one more busy cycle.
    eng_mode = 1; eng_delay = 5;
    wr(8'h08, 32'd3);
    start_log.delete();
    wr(8'h00, 32'd5);
    wait_idle(200, "run3_idle");
    chk("run3_pulses", start_log.size(), 32'd3);
    chk("run3_idx0", log_at(0), 32'd0);
    chk("run3_idx1", log_at(1), 32'd1);
    chk("run3_idx2", log_at(2), 32'd2);
    chk("run3_irq", {31'd0, irq}, 32'd1);
    rd(8'h04, 32'h0202, "run3_status");
    rd(8'h10, 3 * (5 + 1) + 1, "run3_cycles");
    wr(8'h04, 32'h2);
    chk("run3_irq_clr", {31'd0, irq}, 32'd0);
    rd(8'h04, 32'h0200, "run3_status_clr");

    // Timeout: engine silent, 10 WAIT cycles then TMO.
    eng_mode = 0;
    wr(8'h0C, 32'd10);
    wr(8'h08, 32'd2);
    start_log.delete();
    wr(8'h00, 32'd1);
    wait_idle(100, "tmo_idle");
    chk("tmo_pulses", start_log.size(), 32'd1);
    chk("tmo_irq_masked", {31'd0, irq}, 32'd0);
    rd(8'h04, 32'h000A, "tmo_status");
    rd(8'h10, 1 + 10 + 1, "tmo_cycles");
    wr(8'h04, 32'hE);
    wr(8'h0C, 32'd0);

    // err together with done on layer 1.
    eng_mode = 2; eng_delay = 3;
    wr(8'h08, 32'd3);
    start_log.delete();
    wr(8'h00, 32'd1);
    wait_idle(100, "err_idle");
    tick(5);
    chk("err_pulses", start_log.size(), 32'd2);
    rd(8'h04, 32'h0106, "err_status");
    rd(8'h10, 2 * (3 + 1) + 1, "err_cycles");
    wr(8'h04, 32'hE);

    // Config writes and START are ignored while busy.
    eng_mode = 1; eng_delay = 30;
    start_log.delete();
    wr(8'h00, 32'd1);
    rd(8'h04, 32'h0001, "busy_status");
    wr(8'h08, 32'd1);
    rd(8'h08, 32'd3, "busy_lc_kept");
    wr(8'h0C, 32'd5);
    rd(8'h0C, 32'd0, "busy_to_kept");
    wr(8'h00, 32'd1);
    wait_idle(300, "busy_idle");
    chk("busy_pulses", start_log.size(), 32'd3);
    rd(8'h10, 3 * (30 + 1) + 1, "busy_cycles");
    wr(8'h04, 32'hE);

    // ABORT during WAIT of the third layer.
    eng_delay = 8;
    start_log.delete();
    wr(8'h00, 32'd1);
    wait_starts(3, 100);
    wr(8'h00, 32'd2);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    tick(15);
    chk("abort_pulses", start_log.size(), 32'd3);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    rd(8'h04, 32'h0200, "abort_status");
    rd(8'h10, 2 * (8 + 1) + 3, "abort_cycles");
    eng_delay = 2;
    start_log.delete();
    wr(8'h00, 32'd1);
    wait_idle(100, "rerun_idle");
    chk("rerun_pulses", start_log.size(), 32'd3);
    chk("rerun_idx0", log_at(0), 32'd0);
    wr(8'h04, 32'hE);

    // Reset mid-run.
    eng_delay = 10;
    start_log.delete();
    wr(8'h00, 32'd1);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_idx", {30'd0, layer_idx}, 32'd0);
    tick(20);
    chk("mrst_pulses", start_log.size(), 32'd1);
    rd(8'h08, 32'd4, "mrst_layer_cnt");
    rd(8'h10, 32'd0, "mrst_cycles");
    rd(8'h04, 32'd0, "mrst_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
